sync_fifo_flex: RTL

Single-clock, parametrised FIFO that generalises the team's FIFO datapath. It has selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty thresholds, a fill count, overflow and underflow error pulses, and a synchronous flush. It sits between a producer and a consumer in one clock domain and uses the same winc/wdata/wfull and rinc/rdata/rempty handshake as the async FIFO, so the existing driver and monitor clocking blocks reuse unchanged.

---
 rtl/sync_fifo_flex.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with standard or first-word-fall-through
// read mode, programmable almost-full/almost-empty thresholds, a fill count,
// registered overflow/underflow pulses and a synchronous flush.
module sync_fifo_flex #(
    parameter int DSIZE         = 8,
    parameter int ASIZE         = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    output logic             woverflow,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic             runderflow,
    output logic [ASIZE:0]   count
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_THRESH);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_THRESH);
    localparam logic [ASIZE:0] ONE_C    = (ASIZE+1)'(1);

    // Storage; contents are deliberately left unreset.
    logic [DSIZE-1:0] mem [DEPTH];

    // Binary pointers carry one extra wrap bit; only the low bits index mem.
    logic [ASIZE:0] wptr_reg;
    logic [ASIZE:0] rptr_reg;
    logic [ASIZE:0] count_reg;
    logic [ASIZE:0] count_next;
    logic           woverflow_reg;
    logic           runderflow_reg;
    logic           wr_ok;
    logic           rd_ok;
    logic [ASIZE-1:0] widx;
    logic [ASIZE-1:0] ridx;

    assign widx = wptr_reg[ASIZE-1:0];
    assign ridx = rptr_reg[ASIZE-1:0];

    // Status flags decode straight from the registered count.
    assign wfull         = (count_reg == DEPTH_C);
    assign rempty        = (count_reg == '0);
    assign walmost_full  = (count_reg >= AFULL_C);
    assign ralmost_empty = (count_reg <= AEMPTY_C);
    assign count         = count_reg;
    assign woverflow     = woverflow_reg;
    assign runderflow    = runderflow_reg;

    // Flush blocks both sides; full/empty reject the respective request.
    assign wr_ok = winc & ~wfull  & ~clr;
    assign rd_ok = rinc & ~rempty & ~clr;

    // Next fill level: a simultaneous accepted read and write cancel out.
    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + ONE_C;
            2'b01:   count_next = count_reg - ONE_C;
            default: count_next = count_reg;
        endcase
    end

    // Pointer, count and error-pulse registers with flush handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            woverflow_reg  <= 1'b0;
            runderflow_reg <= 1'b0;
        end else if (clr) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            woverflow_reg  <= 1'b0;
            runderflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_reg <= wptr_reg + ONE_C;
            end
            if (rd_ok) begin
                rptr_reg <= rptr_reg + ONE_C;
            end
            count_reg      <= count_next;
            woverflow_reg  <= winc & wfull;
            runderflow_reg <= rinc & rempty;
        end
    end

    // Memory write port; only accepted writes touch the array.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[widx] <= wdata;
        end
    end

    generate
        if (FWFT) begin : gen_fwft
            // Head word is presented combinationally whenever data is stored.
            always_comb begin
                rdata = '0;
                if (!rempty) begin
                    rdata = mem[ridx];
                end
            end
        end else begin : gen_std
            logic [DSIZE-1:0] rdata_reg;

            // Registered read: data appears the cycle after the accepted read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                end else if (clr) begin
                    rdata_reg <= '0;
                end else if (rd_ok) begin
                    rdata_reg <= mem[ridx];
                end
            end

            assign rdata = rdata_reg;
        end
    endgenerate

endmodule
